conv_result_sink: RTL and testbench
===================================

// Module: conv_result_sink
// PURPOSE
//  Consumer end of the conv_2ker output stream (data_o/valid_o/running_o).
//  Converts each valid signed Q-format result to an unsigned pixel with rounding and
//  clamping, then stores it at consecutive addresses of an internal result RAM.
//  Signals frame completion and provides a host/bench read port. Replaces bench-side
//  file dumping in system builds.
// PARAMETERS
//  DATA_WIDTH  32    width of incoming conv result, signed two's complement
//  Q           10    fractional bits of incoming result (Q >= 1)
//  PIX_WIDTH   8     stored pixel width, unsigned
//  DEPTH       9604  result entries per frame ((N-2)^2 for N=100)
//  ADDR_WIDTH  14    address width, 2^ADDR_WIDTH >= DEPTH
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  rst         in   1           synchronous, active-high reset
//  start_i     in   1           arm capture for a new frame (1-cycle pulse)
//  data_i      in   DATA_WIDTH  conv result (conv_2ker data_o)
//  valid_i     in   1           result valid (conv_2ker valid_o)
//  running_i   in   1           conv frame active (conv_2ker running_o)
//  rd_en_i     in   1           read request
//  rd_addr_i   in   ADDR_WIDTH  read address
//  rd_data_o   out  PIX_WIDTH   read data, 1-cycle latency
//  count_o     out  ADDR_WIDTH+1  pixels written this frame
//  busy_o      out  1           high in ARMED or CAPTURE
//  done_o      out  1           frame complete, held until start_i or rst
//  overflow_o  out  1           sticky: beat dropped because count_o == DEPTH
// BEHAVIOUR
//  Reset: FSM=IDLE; rd_data_o, count_o, busy_o, done_o, overflow_o = 0; pipe valids = 0.
//   RAM contents are not cleared.
//  FSM: IDLE --start_i--> ARMED --running_i==1--> CAPTURE --running_i==0 && pipe empty--> DONE.
//   DONE --start_i--> ARMED (count_o, done_o, overflow_o cleared on that edge).
//   start_i in ARMED/CAPTURE: ignored.
//  Accept: beat taken when valid_i && running_i && state in {ARMED, CAPTURE}; else ignored.
//  Conversion (stage 1, registered): r = (data_i + 2^(Q-1)) >>> Q, arithmetic, computed in
//   DATA_WIDTH+1 bits (no wrap). Then r<0 -> 0; r > 2^PIX_WIDTH-1 -> 2^PIX_WIDTH-1; else r.
//   Round half up: 1.5 -> 2, -0.5 -> 0.
//  Write (stage 2): RAM[count_o] <= pixel; count_o += 1 on the same edge.
//   Write lands 2 clocks after the accepted beat. Back-to-back beats give one write per clock.
//  Overflow: accepted beat with count_o == DEPTH (including in-flight) is dropped;
//   overflow_o <= 1. RAM and count_o are unchanged.
//  Completion: CAPTURE waits until both pipe stages are empty after running_i falls,
//   then enters DONE; done_o rises on that edge.
//  Read port: any state. rd_data_o <= RAM[rd_addr_i] when rd_en_i, else holds.
//   Same-address read/write in one cycle returns old data. rd_addr_i >= DEPTH: undefined value.
//  Reset mid-frame: abandons the frame immediately; in-flight beats are discarded.
// STRUCTURE
//  Shared include conv_defs.vh: DATA_WIDTH, Q, N, DEPTH defaults; FSM state codes
//   (IDLE=0, ARMED=1, CAPTURE=2, DONE=3).
//  Sub-module result_ram: 1 write / 1 read port, synchronous read, DEPTH x PIX_WIDTH.
//   Infers BRAM.
//  Top contains: FSM, 2-stage convert/write pipe, counter, flags.
// TESTING (Q=10, PIX_WIDTH=8)
//  1 Convert: start, running=1, beats 0x00000C00, 0x00000600, 0xFFFFFC00, 0x00040000,
//    0x000001FF -> RAM[0..4] = 3, 2, 0, 255, 0; count_o = 5.
//  2 Full frame: DEPTH beats, beat k = (k%256)<<10, running_i drops after the last beat
//    -> done_o 3 clocks after the last beat; count_o = 9604; read k returns k%256.
//  3 Overflow: DEPTH+3 beats -> overflow_o = 1, count_o = 9604, RAM[0] unchanged.
//  4 Idle ignore: valid_i and running_i pulsed without start_i -> count_o = 0, busy_o = 0.
//  5 Mid-frame reset: rst after 10 beats -> all outputs 0; new start + 2 beats ->
//    writes at addr 0 and 1, count_o = 2.
//  6 Gapped valid: valid_i 1,0,0,1,0,1 with values 1.0, 2.0, 3.0 -> RAM[0..2] = 1, 2, 3;
//    contiguous addresses.

Source files
------------

// File: rtl/conv_result_sink_pkg.sv
// Shared defaults and FSM state codes for the conv_2ker result sink.
// Also holds the small helpers the top uses to decode its FSM state.
package conv_result_sink_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int Q_DEF          = 10;
    localparam int PIX_WIDTH_DEF  = 8;
    localparam int N_DEF          = 100;
    localparam int DEPTH_DEF      = (N_DEF - 2) * (N_DEF - 2);
    localparam int ADDR_WIDTH_DEF = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Beats are only taken while a frame is armed or being captured.
    function automatic logic is_capturing(state_t s);
        return (s == ST_ARMED) || (s == ST_CAPTURE);
    endfunction

    // A new frame can only be started from IDLE or DONE; start is ignored otherwise.
    function automatic logic can_rearm(state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/conv_result_sink_result_ram.sv
// Simple dual-port result store: one write port, one synchronous read port.
// Read-during-write to the same address returns the previous contents.
module result_ram #(
    parameter int DEPTH      = 9604,
    parameter int PIX_WIDTH  = 8,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [PIX_WIDTH-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [PIX_WIDTH-1:0]  rd_data
);

    logic [PIX_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset; the array itself keeps its contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/conv_result_sink.sv
// Captures the conv_2ker output stream: rounds/clamps each Q-format result to a
// pixel and stores it at consecutive RAM addresses, flagging frame completion.
module conv_result_sink
    import conv_result_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int Q          = Q_DEF,
    parameter int PIX_WIDTH  = PIX_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    input  logic                  running_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [PIX_WIDTH-1:0]  rd_data_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output state_t                state_o
);

    localparam int                 CNT_W     = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [DATA_WIDTH:0] ROUND    = {{DATA_WIDTH{1'b0}}, 1'b1} << (Q - 1);
    localparam logic [PIX_WIDTH-1:0] PIX_MAX = '1;

    state_t                   state, state_nx;
    logic                     accept, take, rearm;
    logic [CNT_W-1:0]         issue_cnt;
    logic                     s1_valid, s2_valid;
    logic [PIX_WIDTH-1:0]     s1_pix, s2_pix, pix_conv;
    logic signed [DATA_WIDTH:0] rounded, shifted;

    // One guard bit keeps the rounding add from wrapping near the positive limit.
    always_comb begin
        rounded = $signed({data_i[DATA_WIDTH-1], data_i}) + $signed(ROUND);
        shifted = rounded >>> Q;
        if (shifted[DATA_WIDTH]) begin
            pix_conv = '0;
        end else if (|shifted[DATA_WIDTH-1:PIX_WIDTH]) begin
            pix_conv = PIX_MAX;
        end else begin
            pix_conv = shifted[PIX_WIDTH-1:0];
        end
    end

    // issue_cnt counts written plus in-flight beats, so the DEPTH limit covers the pipe.
    assign accept = valid_i && running_i && is_capturing(state);
    assign take   = accept && (issue_cnt != DEPTH_CNT);
    assign rearm  = start_i && can_rearm(state);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start_i) state_nx = ST_ARMED;
            ST_ARMED:   if (running_i) state_nx = ST_CAPTURE;
            ST_CAPTURE: if (!running_i && !s1_valid && !s2_valid) state_nx = ST_DONE;
            ST_DONE:    if (start_i) state_nx = ST_ARMED;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            count_o    <= '0;
            issue_cnt  <= '0;
            overflow_o <= 1'b0;
        end else begin
            state    <= state_nx;
            s1_valid <= take;
            s2_valid <= s1_valid;
            if (rearm) begin
                count_o    <= '0;
                issue_cnt  <= '0;
                overflow_o <= 1'b0;
            end else begin
                if (s2_valid) count_o <= count_o + CNT_W'(1);
                if (take) issue_cnt <= issue_cnt + CNT_W'(1);
                if (accept && !take) overflow_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) s1_pix <= pix_conv;
        if (s1_valid) s2_pix <= s1_pix;
    end

    result_ram #(
        .DEPTH     (DEPTH),
        .PIX_WIDTH (PIX_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (s2_valid),
        .wr_addr(count_o[ADDR_WIDTH-1:0]),
        .wr_data(s2_pix),
        .rd_en  (rd_en_i),
        .rd_addr(rd_addr_i),
        .rd_data(rd_data_o)
    );

    assign busy_o  = is_capturing(state);
    assign done_o  = (state == ST_DONE);
    assign state_o = state;

endmodule

// File: tb/tb_conv_result_sink.sv
// Bench for conv_result_sink: drives frames of conv results, models the frame store
// with a floor-division reference, and checks RAM contents through the read port.
module tb_conv_result_sink;
    import conv_result_sink_pkg::*;

    localparam int DW    = 32;
    localparam int Q     = 10;
    localparam int PW    = 8;
    localparam int DEPTH = 9604;
    localparam int AW    = 14;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          running_i = 1'b0;
    logic          rd_en_i = 1'b0;
    logic [AW-1:0] rd_addr_i = '0;
    logic [PW-1:0] rd_data_o;
    logic [AW:0]   count_o;
    logic          busy_o, done_o, overflow_o;
    state_t        state_o;

    always #5 clk = ~clk;

    conv_result_sink #(
        .DATA_WIDTH(DW), .Q(Q), .PIX_WIDTH(PW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .data_i(data_i), .valid_i(valid_i),
        .running_i(running_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .count_o(count_o), .busy_o(busy_o), .done_o(done_o),
        .overflow_o(overflow_o), .state_o(state_o)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] ref_mem [DEPTH];
    int            ref_count = 0;
    bit            ref_overflow = 1'b0;
    bit            ref_in_frame = 1'b0;
    logic          rd_issued = 1'b0;
    logic [PW-1:0] rd_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion: round-half-up as floor((v + 0.5*2^Q) / 2^Q), then clamp.
    function automatic logic [PW-1:0] model_pix(input logic [DW-1:0] raw);
        longint v, num, q, one, lim;
        one = longint'(1) << Q;
        lim = (longint'(1) << PW) - 1;
        v   = longint'($signed(raw));
        num = v + one / 2;
        q   = num / one;
        if ((num % one) != 0 && num < 0) q = q - 1;
        if (q < 0) q = 0;
        if (q > lim) q = lim;
        return PW'(q);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return DW'($urandom());
            1:       return DW'($urandom_range(0, 300 * 1024));
            2:       return (DW'($urandom_range(0, 255)) << Q) | DW'(512);
            default: return DW'(0) - DW'($urandom_range(0, 4096));
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) rd_issued <= rd_en_i && !rst;

    always @(negedge clk) begin
        if (rd_issued) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0d, expected no read data", rd_data_o);
            end else begin
                rd_exp = exp_q.pop_front();
                check("rd_data", 32'(rd_data_o), 32'(rd_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; start_i = 1'b0; valid_i = 1'b0; running_i = 1'b0; rd_en_i = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        ref_in_frame = 1'b0; ref_count = 0; ref_overflow = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"},    32'(count_o),    32'd0);
        check({tag, "_busy"},     32'(busy_o),     32'd0);
        check({tag, "_done"},     32'(done_o),     32'd0);
        check({tag, "_overflow"}, 32'(overflow_o), 32'd0);
        check({tag, "_rd_data"},  32'(rd_data_o),  32'd0);
        check({tag, "_state"},    32'(state_o),    32'(ST_IDLE));
    endtask

    task automatic do_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        if (!ref_in_frame) begin
            ref_in_frame = 1'b1; ref_count = 0; ref_overflow = 1'b0;
        end
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit v, input bit run);
        data_i = d; valid_i = v; running_i = run;
        cyc();
        if (v && run && ref_in_frame) begin
            if (ref_count < DEPTH) begin
                ref_mem[ref_count] = model_pix(d);
                ref_count++;
            end else begin
                ref_overflow = 1'b1;
            end
        end
    endtask

    // exact: the last cycle driven was an accepted beat, so done_o must rise 3 clocks later.
    task automatic end_frame(input string tag, input bit exact);
        bit seen;
        valid_i = 1'b0; running_i = 1'b0;
        if (exact) begin
            cyc(); cyc();
            check({tag, "_done_early"}, 32'(done_o), 32'd0);
            cyc();
            check({tag, "_done_latency"}, 32'(done_o), 32'd1);
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                cyc();
                seen = done_o;
            end
            check({tag, "_done_timeout"}, 32'(seen), 32'd1);
        end
        ref_in_frame = 1'b0;
        check({tag, "_count"},    32'(count_o),    32'(ref_count));
        check({tag, "_overflow"}, 32'(overflow_o), 32'(ref_overflow));
        check({tag, "_busy"},     32'(busy_o),     32'd0);
    endtask

    task automatic read_expect(input int addr, input logic [PW-1:0] exp);
        rd_en_i = 1'b1; rd_addr_i = AW'(addr);
        exp_q.push_back(exp);
        cyc();
        rd_en_i = 1'b0;
    endtask

    task automatic read_model(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) read_expect(a, ref_mem[a]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        check_all_zero("reset");

        // Idle: beats without start are ignored.
        for (int i = 0; i < 3; i++) beat(DW'(32'h0000_0C00), 1'b1, 1'b1);
        running_i = 1'b0; valid_i = 1'b0;
        cyc();
        check("idle_count", 32'(count_o), 32'd0);
        check("idle_busy",  32'(busy_o),  32'd0);

        // Known conversion vectors, expected pixels written out directly.
        do_start();
        check("armed_busy", 32'(busy_o), 32'd1);
        beat(32'h0000_0C00, 1'b1, 1'b1);
        beat(32'h0000_0600, 1'b1, 1'b1);
        beat(32'hFFFF_FC00, 1'b1, 1'b1);
        beat(32'h0004_0000, 1'b1, 1'b1);
        beat(32'h0000_01FF, 1'b1, 1'b1);
        end_frame("convert", 1'b1);
        check("convert_count5", 32'(count_o), 32'd5);
        read_expect(0, 8'd3); read_expect(1, 8'd2); read_expect(2, 8'd0);
        read_expect(3, 8'd255); read_expect(4, 8'd0);

        // Gapped valid: addresses stay contiguous.
        do_start();
        check("rearm_count_clear", 32'(count_o), 32'd0);
        check("rearm_done_clear",  32'(done_o),  32'd0);
        beat(32'h0000_0400, 1'b1, 1'b1);
        beat(32'h0000_0000, 1'b0, 1'b1);
        beat(32'h0000_0000, 1'b0, 1'b1);
        beat(32'h0000_0800, 1'b1, 1'b1);
        beat(32'h0000_0000, 1'b0, 1'b1);
        beat(32'h0000_0C00, 1'b1, 1'b1);
        end_frame("gapped", 1'b1);
        read_expect(0, 8'd1); read_expect(1, 8'd2); read_expect(2, 8'd3);

        // Randomised frames with gaps and an ignored mid-frame start pulse.
        for (int f = 0; f < 4; f++) begin
            int len;
            len = $urandom_range(20, 60);
            do_start();
            for (int i = 0; i < len; i++) begin
                if (i == len / 2) start_i = 1'b1;
                beat(rand_data(), (i == len - 1) ? 1'b1 : 1'($urandom_range(0, 3) != 0), 1'b1);
                start_i = 1'b0;
            end
            end_frame("random", 1'b1);
            read_model(0, ref_count - 1);
        end

        // Full frame: exactly DEPTH beats, no overflow.
        do_start();
        for (int k = 0; k < DEPTH; k++) beat(DW'(k % 256) << Q, 1'b1, 1'b1);
        end_frame("full", 1'b1);
        check("full_count", 32'(count_o), 32'(DEPTH));
        for (int k = 0; k < DEPTH; k++) read_expect(k, PW'(k % 256));

        // Beats while DONE are ignored.
        beat(32'h0000_1400, 1'b1, 1'b1);
        valid_i = 1'b0; running_i = 1'b0;
        cyc();
        check("done_ignore_count", 32'(count_o), 32'(DEPTH));
        check("done_ignore_done",  32'(done_o),  32'd1);

        // Overflow: DEPTH+3 beats; flag rises on the first dropped beat only.
        do_start();
        for (int k = 0; k < DEPTH + 3; k++) begin
            beat(rand_data(), 1'b1, 1'b1);
            if (k == DEPTH - 1) check("ovf_at_depth",  32'(overflow_o), 32'd0);
            if (k == DEPTH)     check("ovf_past_depth", 32'(overflow_o), 32'd1);
        end
        end_frame("overflow", 1'b0);
        check("overflow_count", 32'(count_o), 32'(DEPTH));
        read_expect(0, ref_mem[0]);
        read_expect(1, ref_mem[1]);
        read_expect(DEPTH - 1, ref_mem[DEPTH - 1]);

        // Mid-frame reset abandons the frame, including in-flight beats.
        do_start();
        for (int k = 0; k < 10; k++) beat(rand_data(), 1'b1, 1'b1);
        do_reset();
        check_all_zero("midrst");
        do_start();
        beat(32'h0000_1400, 1'b1, 1'b1);
        beat(32'h0000_1C00, 1'b1, 1'b1);
        end_frame("after_rst", 1'b1);
        check("after_rst_count", 32'(count_o), 32'd2);
        read_expect(0, 8'd5);
        read_expect(1, 8'd7);

        repeat (3) cyc();
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
